digit_projection: RTL and testbench

Projection front end of the digit-recognition path. It scans one binary frame to find the row band and column bands that contain black pixels. It writes the low/high and left/right border pairs into the row and column border RAMs, then reports the segment counts and a done flag. `digital_recognition` reads those RAMs back during recognition frame 2.

---
 rtl/digit_proj_pkg.sv | 12 +
 rtl/digit_projection_if.sv | 29 ++
 rtl/seg_border_tracker.sv | 75 +++++++
 rtl/digit_projection.sv | 93 +++++++++
 tb/tb_digit_projection.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/digit_proj_pkg.sv
// digit_proj_pkg: shared types, encodings and border RAM address mapping for digit_projection.
package digit_proj_pkg;
  localparam int BORDER_W = 11;
  typedef enum logic [2:0] {IDLE, PROJ, CSCAN, WAIT1, RECOG} state_e;
  localparam logic [1:0] FC_PROJ  = 2'd0;
  localparam logic [1:0] FC_SCAN  = 2'd1;
  localparam logic [1:0] FC_RECOG = 2'd2;
  localparam logic [1:0] FC_IDLE  = 2'd3;
  function automatic logic [BORDER_W-1:0] seg_addr(input logic [3:0] seg, input logic hi);
    return {{(BORDER_W-5){1'b0}}, seg, hi};
  endfunction
endpackage

// File: rtl/digit_projection_if.sv
// digit_projection_if: pixel stream in, border RAM write ports and projection status out.
interface digit_projection_if;
  logic        pixel_de;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic        monoc;
  logic        row_border_we;
  logic [10:0] row_border_addr;
  logic [10:0] row_border_wdata;
  logic        col_border_we;
  logic [10:0] col_border_addr;
  logic [10:0] col_border_wdata;
  logic [1:0]  frame_cnt;
  logic        project_done_flag;
  logic [3:0]  num_row;
  logic [3:0]  num_col;
  modport master (
    output pixel_de, xpos, ypos, monoc,
    input  row_border_we, row_border_addr, row_border_wdata,
    input  col_border_we, col_border_addr, col_border_wdata,
    input  frame_cnt, project_done_flag, num_row, num_col
  );
  modport slave (
    input  pixel_de, xpos, ypos, monoc,
    output row_border_we, row_border_addr, row_border_wdata,
    output col_border_we, col_border_addr, col_border_wdata,
    output frame_cnt, project_done_flag, num_row, num_col
  );
endinterface

// File: rtl/seg_border_tracker.sv
// seg_border_tracker: turns a stream of per-position hit flags into low/high border writes and a segment count.
module seg_border_tracker
  import digit_proj_pkg::*;
#(
  parameter int MAX_SEG = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hit,
  input  logic [BORDER_W-1:0] pos,
  input  logic                last,
  input  logic                en,
  input  logic                clr,
  output logic                we,
  output logic [BORDER_W-1:0] addr,
  output logic [BORDER_W-1:0] wdata,
  output logic [3:0]          cnt
);
  logic                we_q, we_d, in_seg_q, in_seg_d, pend_q, pend_d;
  logic [BORDER_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]          cnt_q, cnt_d;
  always_comb begin
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    in_seg_d = in_seg_q;
    pend_d   = 1'b0;
    if (clr) begin
      cnt_d    = '0;
      in_seg_d = 1'b0;
    end else if (pend_q) begin
      // segment opened on the last position: its high border equals its low border
      we_d     = 1'b1;
      addr_d   = addr_q + 1'b1;
      cnt_d    = cnt_q + 1'b1;
      in_seg_d = 1'b0;
    end else if (en) begin
      if (!in_seg_q && hit && cnt_q < 4'(MAX_SEG)) begin
        we_d     = 1'b1;
        addr_d   = seg_addr(cnt_q, 1'b0);
        wdata_d  = pos;
        in_seg_d = 1'b1;
        pend_d   = last;
      end else if (in_seg_q && (!hit || last)) begin
        we_d     = 1'b1;
        addr_d   = seg_addr(cnt_q, 1'b1);
        wdata_d  = hit ? pos : pos - 1'b1;
        cnt_d    = cnt_q + 1'b1;
        in_seg_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      in_seg_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      in_seg_q <= in_seg_d;
      pend_q   <= pend_d;
    end
  end
  assign we    = we_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign cnt   = cnt_q;
endmodule

// File: rtl/digit_projection.sv
// digit_projection: finds row and column bands of black pixels in one frame and writes their borders to RAM.
module digit_projection
  import digit_proj_pkg::*;
#(
  parameter int NUM_ROW = 1,
  parameter int NUM_COL = 4,
  parameter int H_PIXEL = 480,
  parameter int V_PIXEL = 272
) (
  input logic               clk,
  input logic               rst_n,
  digit_projection_if.slave bus
);
  localparam int XW = $clog2(H_PIXEL);
  state_e              state_q, state_d;
  logic [H_PIXEL-1:0]  col_hit_q, col_hit_d;
  logic                line_hit_q, line_hit_d, flag_q, flag_d;
  logic [BORDER_W-1:0] scan_q, scan_d;
  logic                px_black, le, fe, proj_entry, scan_last;
  assign px_black   = bus.pixel_de && !bus.monoc;
  assign le         = bus.pixel_de && bus.xpos == BORDER_W'(H_PIXEL - 1);
  assign fe         = le && bus.ypos == BORDER_W'(V_PIXEL - 1);
  assign proj_entry = fe && (state_q == IDLE || state_q == RECOG);
  assign scan_last  = scan_q == BORDER_W'(H_PIXEL - 1);
  always_comb begin
    state_d    = state_q;
    col_hit_d  = col_hit_q;
    line_hit_d = line_hit_q;
    scan_d     = scan_q;
    flag_d     = flag_q;
    case (state_q)
      IDLE:  state_d = fe ? PROJ : IDLE;
      PROJ: begin
        state_d = fe ? CSCAN : PROJ;
        scan_d  = '0;
      end
      CSCAN: begin
        scan_d  = scan_q + 1'b1;
        state_d = scan_last ? WAIT1 : CSCAN;
        flag_d  = flag_q | scan_last;
      end
      WAIT1: state_d = fe ? RECOG : WAIT1;
      RECOG: state_d = fe ? PROJ : RECOG;
      default: state_d = IDLE;
    endcase
    if (state_q == PROJ && px_black) begin
      line_hit_d = 1'b1;
      if (bus.xpos < BORDER_W'(H_PIXEL)) col_hit_d[bus.xpos[XW-1:0]] = 1'b1;
    end
    if (le) line_hit_d = 1'b0;
    if (proj_entry) begin
      col_hit_d  = '0;
      line_hit_d = 1'b0;
      flag_d     = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_hit_q  <= '0;
      line_hit_q <= 1'b0;
      scan_q     <= '0;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_hit_q  <= col_hit_d;
      line_hit_q <= line_hit_d;
      scan_q     <= scan_d;
      flag_q     <= flag_d;
    end
  end
  // the current LE pixel itself counts toward its line's hit
  seg_border_tracker #(.MAX_SEG(NUM_ROW)) u_row (
    .clk(clk), .rst_n(rst_n),
    .hit(line_hit_q | px_black), .pos(bus.ypos),
    .last(bus.ypos == BORDER_W'(V_PIXEL - 1)),
    .en(state_q == PROJ && le), .clr(proj_entry),
    .we(bus.row_border_we), .addr(bus.row_border_addr),
    .wdata(bus.row_border_wdata), .cnt(bus.num_row)
  );
  seg_border_tracker #(.MAX_SEG(NUM_COL)) u_col (
    .clk(clk), .rst_n(rst_n),
    .hit(col_hit_q[scan_q[XW-1:0]]), .pos(scan_q),
    .last(scan_last),
    .en(state_q == CSCAN), .clr(proj_entry),
    .we(bus.col_border_we), .addr(bus.col_border_addr),
    .wdata(bus.col_border_wdata), .cnt(bus.num_col)
  );
  assign bus.frame_cnt = state_q == IDLE  ? FC_IDLE  :
                         state_q == PROJ  ? FC_PROJ  :
                         state_q == RECOG ? FC_RECOG : FC_SCAN;
  assign bus.project_done_flag = flag_q;
endmodule

// File: tb/tb_digit_projection.sv
// tb_digit_projection: drives small binary frames and checks border writes against a projection model.
module tb_digit_projection;
  localparam int H = 32, V = 16, NR = 2, NC = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  digit_projection_if bus();
  digit_projection #(.NUM_ROW(NR), .NUM_COL(NC), .H_PIXEL(H), .V_PIXEL(V)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int checks = 0, fails = 0;
  bit img [V][H];
  int rlog_a[$], rlog_d[$], clog_a[$], clog_d[$];
  int erow_a[$], erow_d[$], ecol_a[$], ecol_d[$];
  int exp_nr, exp_nc;

  always @(negedge clk) begin
    if (bus.row_border_we === 1'b1) begin
      rlog_a.push_back(int'(bus.row_border_addr));
      rlog_d.push_back(int'(bus.row_border_wdata));
    end
    if (bus.col_border_we === 1'b1) begin
      clog_a.push_back(int'(bus.col_border_addr));
      clog_d.push_back(int'(bus.col_border_wdata));
    end
  end

  task automatic tick(input bit de, input int x, input int y, input bit m);
    @(posedge clk); #1;
    bus.pixel_de = de; bus.xpos = 11'(x); bus.ypos = 11'(y); bus.monoc = m;
  endtask
  task automatic idle(input int n);
    repeat (n) tick(1'b0, 0, 0, 1'b1);
  endtask
  task automatic drive_rows(input int y0, input int y1);
    for (int y = y0; y <= y1; y++) begin
      if (y != y0) idle(2);
      for (int x = 0; x < H; x++) tick(1'b1, x, y, !img[y][x]);
    end
  endtask
  task automatic clear_logs();
    rlog_a.delete(); rlog_d.delete(); clog_a.delete(); clog_d.delete();
  endtask
  task automatic clear_img();
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) img[y][x] = 1'b0;
  endtask
  task automatic add_rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++) for (int x = x0; x <= x1; x++) img[y][x] = 1'b1;
  endtask
  task automatic push_exp(input bit col, input int a, input int d);
    if (col) begin ecol_a.push_back(a); ecol_d.push_back(d); end
    else begin erow_a.push_back(a); erow_d.push_back(d); end
  endtask
  // runs of set flags become segments; runs starting after the cap are dropped
  task automatic model_seg(input bit p[64], input int n, input int mx, input bit col, output int cnt);
    int lo = 0;
    bit ins = 1'b0;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (p[i] && !ins && cnt < mx) begin ins = 1'b1; lo = i; end
      else if (!p[i] && ins) begin
        push_exp(col, 2*cnt, lo); push_exp(col, 2*cnt+1, i-1); cnt++; ins = 1'b0;
      end
    end
    if (ins) begin push_exp(col, 2*cnt, lo); push_exp(col, 2*cnt+1, n-1); cnt++; end
  endtask
  task automatic build_exp();
    bit p[64];
    erow_a.delete(); erow_d.delete(); ecol_a.delete(); ecol_d.delete();
    for (int i = 0; i < 64; i++) p[i] = 1'b0;
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) if (img[y][x]) p[y] = 1'b1;
    model_seg(p, V, NR, 1'b0, exp_nr);
    for (int i = 0; i < 64; i++) p[i] = 1'b0;
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) if (img[y][x]) p[x] = 1'b1;
    model_seg(p, H, NC, 1'b1, exp_nc);
  endtask

  // one full PROJ -> CSCAN/WAIT1 -> RECOG -> PROJ cycle with the current image
  task automatic project_frame(input string tag);
    int ga, gd;
    clear_logs();
    build_exp();
    drive_rows(0, V-1);
    checks++; if (bus.frame_cnt !== 2'd0) begin fails++; $display("FAIL %s fc_before_fe: got %0d want 0", tag, bus.frame_cnt); end
    idle(1);
    checks++; if (bus.frame_cnt !== 2'd1) begin fails++; $display("FAIL %s fc_scan: got %0d want 1", tag, bus.frame_cnt); end
    idle(H-1);
    checks++; if (bus.project_done_flag !== 1'b0) begin fails++; $display("FAIL %s flag_early: got %0b want 0", tag, bus.project_done_flag); end
    idle(1);
    checks++; if (bus.project_done_flag !== 1'b1) begin fails++; $display("FAIL %s flag_rise: got %0b want 1", tag, bus.project_done_flag); end
    idle(3);
    checks++; if (bus.num_row !== 4'(exp_nr)) begin fails++; $display("FAIL %s num_row: got %0d want %0d", tag, bus.num_row, exp_nr); end
    checks++; if (bus.num_col !== 4'(exp_nc)) begin fails++; $display("FAIL %s num_col: got %0d want %0d", tag, bus.num_col, exp_nc); end
    checks++; if (rlog_a.size() != erow_a.size()) begin fails++; $display("FAIL %s row_wr_count: got %0d want %0d", tag, rlog_a.size(), erow_a.size()); end
    checks++; if (clog_a.size() != ecol_a.size()) begin fails++; $display("FAIL %s col_wr_count: got %0d want %0d", tag, clog_a.size(), ecol_a.size()); end
    for (int i = 0; i < erow_a.size(); i++) begin
      ga = i < rlog_a.size() ? rlog_a[i] : -1;
      gd = i < rlog_d.size() ? rlog_d[i] : -1;
      checks++;
      if (ga != erow_a[i] || gd != erow_d[i]) begin
        fails++; $display("FAIL %s row_wr[%0d]: got addr %0d data %0d want addr %0d data %0d", tag, i, ga, gd, erow_a[i], erow_d[i]);
      end
    end
    for (int i = 0; i < ecol_a.size(); i++) begin
      ga = i < clog_a.size() ? clog_a[i] : -1;
      gd = i < clog_d.size() ? clog_d[i] : -1;
      checks++;
      if (ga != ecol_a[i] || gd != ecol_d[i]) begin
        fails++; $display("FAIL %s col_wr[%0d]: got addr %0d data %0d want addr %0d data %0d", tag, i, ga, gd, ecol_a[i], ecol_d[i]);
      end
    end
    drive_rows(0, V-1);
    checks++; if (bus.frame_cnt !== 2'd1) begin fails++; $display("FAIL %s fc_wait1: got %0d want 1", tag, bus.frame_cnt); end
    idle(1);
    checks++; if (bus.frame_cnt !== 2'd2) begin fails++; $display("FAIL %s fc_recog: got %0d want 2", tag, bus.frame_cnt); end
    checks++; if (bus.project_done_flag !== 1'b1) begin fails++; $display("FAIL %s flag_recog: got %0b want 1", tag, bus.project_done_flag); end
    checks++; if (rlog_a.size() + clog_a.size() != erow_a.size() + ecol_a.size()) begin
      fails++; $display("FAIL %s stray_writes: got %0d want %0d", tag, rlog_a.size() + clog_a.size(), erow_a.size() + ecol_a.size());
    end
    drive_rows(0, V-1);
    idle(1);
    checks++; if (bus.frame_cnt !== 2'd0) begin fails++; $display("FAIL %s fc_reproj: got %0d want 0", tag, bus.frame_cnt); end
    checks++; if (bus.project_done_flag !== 1'b0 || bus.num_row !== 4'd0 || bus.num_col !== 4'd0) begin
      fails++; $display("FAIL %s entry_clear: got flag %0b rows %0d cols %0d want 0 0 0", tag, bus.project_done_flag, bus.num_row, bus.num_col);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pixel_de = 1'b0; bus.xpos = '0; bus.ypos = '0; bus.monoc = 1'b1;
    repeat (3) tick(1'b0, 0, 0, 1'b1);
    checks++; if (bus.frame_cnt !== 2'd3) begin fails++; $display("FAIL reset_fc: got %0d want 3", bus.frame_cnt); end
    checks++; if (bus.row_border_we !== 1'b0 || bus.col_border_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %0b %0b want 0 0", bus.row_border_we, bus.col_border_we); end
    checks++; if ({bus.row_border_addr, bus.row_border_wdata, bus.col_border_addr, bus.col_border_wdata} !== 44'd0) begin
      fails++; $display("FAIL reset_addr_data: got %0h want 0", {bus.row_border_addr, bus.row_border_wdata, bus.col_border_addr, bus.col_border_wdata});
    end
    checks++; if (bus.num_row !== 4'd0 || bus.num_col !== 4'd0 || bus.project_done_flag !== 1'b0) begin
      fails++; $display("FAIL reset_status: got rows %0d cols %0d flag %0b want 0 0 0", bus.num_row, bus.num_col, bus.project_done_flag);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_no_mid_start();
    clear_img(); add_rect(0, H-1, 0, V-1);
    clear_logs();
    drive_rows(V/2, V-1);
    checks++; if (bus.frame_cnt !== 2'd3) begin fails++; $display("FAIL idle_mid_frame_fc: got %0d want 3", bus.frame_cnt); end
    idle(1);
    checks++; if (bus.frame_cnt !== 2'd0) begin fails++; $display("FAIL idle_to_proj_fc: got %0d want 0", bus.frame_cnt); end
    checks++; if (rlog_a.size() + clog_a.size() != 0) begin fails++; $display("FAIL idle_writes: got %0d want 0", rlog_a.size() + clog_a.size()); end
  endtask

  task automatic test_reset_mid();
    clear_img(); add_rect(4, 9, 2, 12);
    drive_rows(0, 7);
    @(posedge clk); #1; rst_n = 1'b0; bus.pixel_de = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.frame_cnt !== 2'd3 || bus.num_row !== 4'd0 || bus.row_border_we !== 1'b0) begin
      fails++; $display("FAIL mid_reset: got fc %0d rows %0d we %0b want 3 0 0", bus.frame_cnt, bus.num_row, bus.row_border_we);
    end
    rst_n = 1'b1;
    clear_logs();
    drive_rows(8, V-1);
    checks++; if (bus.frame_cnt !== 2'd3) begin fails++; $display("FAIL mid_reset_idle_fc: got %0d want 3", bus.frame_cnt); end
    idle(1);
    checks++; if (rlog_a.size() + clog_a.size() != 0) begin fails++; $display("FAIL mid_reset_writes: got %0d want 0", rlog_a.size() + clog_a.size()); end
    checks++; if (bus.frame_cnt !== 2'd0) begin fails++; $display("FAIL mid_reset_proj_fc: got %0d want 0", bus.frame_cnt); end
    project_frame("after_reset");
  endtask

  task automatic test_single_block();
    clear_img(); add_rect(10, 17, 4, 9);
    project_frame("single_block");
  endtask
  task automatic test_four_blocks();
    clear_img();
    for (int k = 0; k < 4; k++) add_rect(2 + 6*k, 5 + 6*k, 3, 12);
    project_frame("four_blocks");
  endtask
  task automatic test_overflow();
    clear_img();
    for (int k = 0; k < 5; k++) add_rect(1 + 5*k, 2 + 5*k, 1, 3);
    add_rect(1, 2, 6, 7); add_rect(1, 2, 10, 11);
    project_frame("overflow");
  endtask
  task automatic test_edge();
    clear_img(); add_rect(28, 31, 12, 15);
    project_frame("edge_close");
  endtask
  task automatic test_last_line();
    clear_img(); add_rect(3, 5, 2, 4); add_rect(31, 31, 15, 15);
    project_frame("last_line");
  endtask
  task automatic test_blank();
    clear_img();
    project_frame("blank");
  endtask
  task automatic test_random();
    int n, x0, y0;
    for (int r = 0; r < 4; r++) begin
      clear_img();
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        x0 = $urandom_range(0, H-1); y0 = $urandom_range(0, V-1);
        add_rect(x0, (x0 + $urandom_range(0, 5)) % H > x0 ? (x0 + $urandom_range(0, 5)) % H : x0,
                 y0, (y0 + $urandom_range(0, 3)) % V > y0 ? (y0 + $urandom_range(0, 3)) % V : y0);
      end
      for (int k = 0; k < 6; k++) img[$urandom_range(0, V-1)][$urandom_range(0, H-1)] = 1'b1;
      project_frame($sformatf("random%0d", r));
    end
  endtask

  initial begin
    test_reset();
    test_no_mid_start();
    test_single_block();
    test_four_blocks();
    test_overflow();
    test_edge();
    test_last_line();
    test_blank();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
